// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - single-clock parameterised FIFO with registered read data and sticky error flags
module fifo_param #(
  parameter int WIDTH    = 10,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         in,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         out,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rd_acc;
  logic             wr_acc;

  assign empty        = (count == (AW+1)'(0));
  assign full         = (count == (AW+1)'(DEPTH));
  assign almost_empty = (count <= (AW+1)'(AE_LEVEL));
  assign almost_full  = (count >= (AW+1)'(AF_LEVEL));

  // A write into a full FIFO is still taken when a read frees a slot on the same edge.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  // Storage is deliberately left out of reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_acc && !clr) begin
      mem[wr_ptr] <= in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out       <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        out    <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (wr_en && !wr_acc) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - self-checking bench for fifo_param (vector table, directed corners, random vs queue model)
module tb_fifo_param;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       wr_en;
  logic [9:0] din;
  logic       rd_en;
  logic [9:0] dout;
  logic       empty;
  logic       full;
  logic       almost_empty;
  logic       almost_full;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  fifo_param #(.WIDTH(10), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .in(din), .rd_en(rd_en),
    .out(dout), .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a plain queue of stored words plus the visible registers.
  int         mq[$];
  logic [9:0] m_out;
  bit         m_ovf;
  bit         m_udf;

  typedef struct {
    bit         wr;
    bit         rd;
    logic [9:0] din;
    logic [9:0] e_out;
    int         e_cnt;
    bit         e_ovf;
    bit         e_udf;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(string tag);
    int n;
    n = mq.size();
    chk({tag, " out"},          32'(dout),         32'(m_out));
    chk({tag, " count"},        32'(count),        32'(n));
    chk({tag, " empty"},        32'(empty),        32'(n == 0));
    chk({tag, " full"},         32'(full),         32'(n == 16));
    chk({tag, " almost_empty"}, 32'(almost_empty), 32'(n <= 2));
    chk({tag, " almost_full"},  32'(almost_full),  32'(n >= 14));
    chk({tag, " overflow"},     32'(overflow),     32'(m_ovf));
    chk({tag, " underflow"},    32'(underflow),    32'(m_udf));
  endtask

  task automatic model_edge(bit c, bit w, bit r, logic [9:0] d);
    int n;
    bit racc;
    bit wacc;
    n    = mq.size();
    racc = r && (n > 0);
    wacc = w && ((n < 16) || racc);
    if (c) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (racc) m_out = 10'(mq.pop_front());
      if (wacc) mq.push_back(int'(d));
      if (w && !wacc) m_ovf = 1'b1;
      if (r && n == 0) m_udf = 1'b1;
    end
  endtask

  task automatic step(bit c, bit w, bit r, logic [9:0] d);
    @(negedge clk);
    clr = c; wr_en = w; rd_en = r; din = d;
    @(posedge clk);
    model_edge(c, w, r, d);
    #1;
    clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_out = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  // Reset is asserted mid-cycle so its effect must be visible before any clock edge.
  task automatic do_reset(string tag);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    chk({tag, " async count"}, 32'(count), 32'd0);
    chk({tag, " async out"},   32'(dout),  32'd0);
    chk({tag, " async empty"}, 32'(empty), 32'd1);
    chk_model({tag, " reset"});
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    model_reset();

    // Vector table: read on empty, fill to full, one overflow, drain.
    tbl.push_back('{0, 1, 10'd0, 10'd0, 0, 0, 1});
    for (int i = 1; i <= 16; i++) tbl.push_back('{1, 0, 10'(10 * i), 10'd0, i, 0, 1});
    tbl.push_back('{1, 0, 10'd170, 10'd0, 16, 1, 1});
    for (int i = 1; i <= 16; i++) tbl.push_back('{0, 1, 10'd0, 10'(10 * i), 16 - i, 1, 1});

    #12;
    chk_model("por");
    rst = 1'b1;

    foreach (tbl[k]) begin
      step(0, tbl[k].wr, tbl[k].rd, tbl[k].din);
      chk($sformatf("vec%0d out", k),   32'(dout),         32'(tbl[k].e_out));
      chk($sformatf("vec%0d count", k), 32'(count),        32'(tbl[k].e_cnt));
      chk($sformatf("vec%0d empty", k), 32'(empty),        32'(tbl[k].e_cnt == 0));
      chk($sformatf("vec%0d full", k),  32'(full),         32'(tbl[k].e_cnt == 16));
      chk($sformatf("vec%0d ae", k),    32'(almost_empty), 32'(tbl[k].e_cnt <= 2));
      chk($sformatf("vec%0d af", k),    32'(almost_full),  32'(tbl[k].e_cnt >= 14));
      chk($sformatf("vec%0d ovf", k),   32'(overflow),     32'(tbl[k].e_ovf));
      chk($sformatf("vec%0d udf", k),   32'(underflow),    32'(tbl[k].e_udf));
    end

    // Simultaneous read/write at full, then at empty.
    do_reset("full_rw");
    for (int i = 1; i <= 16; i++) step(0, 1, 0, 10'(10 * i));
    step(0, 1, 1, 10'd999);
    chk("full_rw count", 32'(count), 32'd16);
    chk("full_rw out",   32'(dout),  32'd10);
    chk_model("full_rw");
    for (int j = 0; j < 16; j++) begin
      step(0, 0, 1, 10'd0);
      chk($sformatf("full_rw rd%0d", j), 32'(dout), (j < 15) ? 32'(10 * (j + 2)) : 32'd999);
      chk_model("full_rw drain");
    end
    step(0, 1, 1, 10'd77);
    chk("empty_rw out",   32'(dout),  32'd999);
    chk("empty_rw count", 32'(count), 32'd1);
    chk_model("empty_rw");
    step(0, 0, 1, 10'd0);
    chk("empty_rw rd", 32'(dout), 32'd77);

    // Pointer wrap with a single word in flight.
    do_reset("wrap");
    for (int i = 1; i <= 40; i++) begin
      step(0, 1, 0, 10'(i));
      chk($sformatf("wrap cnt_w%0d", i), 32'(count), 32'd1);
      step(0, 0, 1, 10'd0);
      chk($sformatf("wrap out%0d", i), 32'(dout), 32'(i));
      chk_model("wrap");
    end

    // Reset mid-operation discards contents.
    do_reset("midrst pre");
    for (int i = 0; i < 5; i++) step(0, 1, 0, 10'(300 + i));
    do_reset("midrst");
    step(0, 1, 0, 10'd123);
    step(0, 0, 1, 10'd0);
    chk("midrst first word", 32'(dout), 32'd123);
    chk_model("midrst");

    // clr with a concurrent write clears state and drops the write.
    step(0, 0, 1, 10'd0);
    for (int i = 0; i < 17; i++) step(0, 1, 0, 10'(500 + i));
    chk("clr pre ovf", 32'(overflow),  32'd1);
    chk("clr pre udf", 32'(underflow), 32'd1);
    step(1, 1, 0, 10'd55);
    chk("clr count", 32'(count),     32'd0);
    chk("clr ovf",   32'(overflow),  32'd0);
    chk("clr udf",   32'(underflow), 32'd0);
    chk("clr out",   32'(dout),      32'd123);
    chk_model("clr");
    step(0, 0, 1, 10'd0);
    chk_model("clr after");

    // Randomised traffic with drifting write/read bias.
    for (int i = 0; i < 3000; i++) begin
      int pw;
      int pr;
      pw = ((i / 200) % 3 == 0) ? 80 : (((i / 200) % 3 == 1) ? 25 : 55);
      pr = 100 - pw;
      step(($urandom_range(127, 0) == 0),
           ($urandom_range(99, 0) < pw),
           ($urandom_range(99, 0) < pr),
           10'($urandom_range(1023, 0)));
      chk_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 Parameter WIDTH, default 10, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of storage words; power of two, >=2.
REQ-003 Parameter AF_LEVEL, default 14, almost_full threshold in words (1..DEPTH).
REQ-004 Parameter AE_LEVEL, default 2, almost_empty threshold in words (0..DEPTH-1).
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 clr  input  1  synchronous flush, active-high.
REQ-008 wr_en  input  1  write request.
REQ-009 in  input  WIDTH  write data.
REQ-010 rd_en  input  1  read request.
REQ-011 out  output  WIDTH  registered read data.
REQ-012 empty  output  1  count == 0.
REQ-013 full  output  1  count == DEPTH.
REQ-014 almost_empty  output  1  count <= AE_LEVEL.
REQ-015 almost_full  output  1  count >= AF_LEVEL.
REQ-016 count  output  log2(DEPTH)+1  words currently stored.
REQ-017 overflow  output  1  sticky: write dropped.
REQ-018 underflow  output  1  sticky: read on empty.

Function
REQ-019 Storage SHALL be a DEPTH x WIDTH array with log2(DEPTH)-bit write and read pointers wrapping from DEPTH-1 to 0.
REQ-020 Read accepted SHALL be rd_en && !empty; write accepted SHALL be wr_en && (!full || read accepted).
REQ-021 Accepted write SHALL store in at the write pointer and increment it on the same edge.
REQ-022 Accepted read SHALL load out with the word at the read pointer and increment it on that edge; out SHALL hold its value otherwise.
REQ-023 Read latency SHALL be one edge: data appears on out immediately after the accepting edge.
REQ-024 count SHALL +1 on write-only, -1 on read-only, unchanged on both or neither.
REQ-025 Full with rd_en and wr_en both high SHALL accept both, count stays DEPTH, FIFO order preserved.
REQ-026 Empty with rd_en and wr_en both high SHALL accept only the write (no fall-through); out unchanged; count becomes 1.
REQ-027 Flags empty, full, almost_empty, almost_full SHALL be decoded combinationally from count.
REQ-028 overflow SHALL set on any edge with wr_en high and write not accepted; underflow SHALL set on any edge with rd_en high while empty; both hold until clr or reset.
REQ-029 clr SHALL have priority over rd_en/wr_en: pointers, count, overflow, underflow to 0; out holds; memory contents unchanged.

Reset
REQ-030 rst low SHALL immediately, without waiting for clk, force out=0, count=0, pointers=0, overflow=0, underflow=0, hence empty=1, almost_empty=1, full=0, almost_full=0.
REQ-031 Memory array SHALL NOT be reset.
REQ-032 Reset asserted mid-operation SHALL discard all stored words; first post-reset write lands at address 0.

Verification (defaults WIDTH=10, DEPTH=16)
REQ-033 Reset, then rd_en=1 for one edge -> out=0, count=0, empty=1, underflow=1.
REQ-034 Write 10,20,...,160 on 16 edges -> almost_full=1 after 14th, full=1 and count=16 after 16th; 17th write 170 -> rejected, overflow=1, count=16.
REQ-035 Then read 16 edges -> out sequence 10,20,...,160; almost_empty=1 once count<=2; empty=1 after last read; out holds 160.
REQ-036 At full, rd_en=wr_en=1 writing 999 -> count=16, out=10; subsequent reads return 20..160 then 999.
REQ-037 Interleave 40 write/read pairs (values 1..40) -> pointers wrap twice, out returns 1..40 in order, count never exceeds 1.
REQ-038 Write 5 words, pulse rst low between edges -> count=0, empty=1, out=0 asynchronously; separately clr with wr_en=1 -> count=0, overflow/underflow cleared, write ignored.
